// File: rtl/tap_bank_ctrl.sv
// Double-buffered coefficient banks for the decimator, Hilbert and interpolator filters.
// Optional feature: define TAP_BANK_READBACK_EN to add rd_en/rd_data shadow readback.

module tap_bank_slot #(
  parameter int                      LEN = 8,
  parameter logic [LEN-1:0][15:0]    DEF = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic                       swap,
  input  logic [4:0]                 addr,
  input  logic [15:0]                data,
  output logic [LEN-1:0][15:0]       tap
`ifdef TAP_BANK_READBACK_EN
  ,
  output logic [15:0]                rd
`endif
);
  logic [LEN-1:0][15:0] shadow;

  // Writes and swaps never coincide: writes happen in IDLE, swaps in ARMED.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= DEF;
      tap    <= DEF;
    end else begin
      for (int i = 0; i < LEN; i++)
        if (we && addr == 5'(i)) shadow[i] <= data;
      if (swap) tap <= shadow;
    end
  end

`ifdef TAP_BANK_READBACK_EN
  always_comb begin
    rd = '0;
    for (int i = 0; i < LEN; i++)
      if (addr == 5'(i)) rd = shadow[i];
  end
`endif
endmodule

module tap_bank_ctrl #(
  parameter int                            tap_len_deci = 21,
  parameter int                            m_len        = 8,
  parameter int                            tap_len_intp = 21,
  parameter logic [tap_len_deci-1:0][15:0] def_deci     = '0,
  parameter logic [m_len-1:0][15:0]        def_hilb     = '0,
  parameter logic [tap_len_intp-1:0][15:0] def_intp     = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [1:0]                       wr_sel,
  input  logic [4:0]                       wr_addr,
  input  logic [15:0]                      wr_data,
  input  logic                             commit,
  input  logic                             sync,
  input  logic                             err_clr,
`ifdef TAP_BANK_READBACK_EN
  input  logic                             rd_en,
  output logic [15:0]                      rd_data,
`endif
  output logic                             busy,
  output logic                             swap_done,
  output logic                             err,
  output logic [tap_len_deci-1:0][15:0]    tap_deci,
  output logic [m_len-1:0][15:0]           tap_hilb,
  output logic [tap_len_intp-1:0][15:0]    tap_intp
);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  logic [0:0] state;
  logic       idle, sel_ok, wr_go, wr_bad, rd_bad, swap;

  always_comb begin
    sel_ok = 1'b0;
    case (wr_sel)
      2'd0:    sel_ok = int'(wr_addr) < tap_len_deci;
      2'd1:    sel_ok = int'(wr_addr) < m_len;
      2'd2:    sel_ok = int'(wr_addr) < tap_len_intp;
      default: sel_ok = 1'b0;
    endcase
  end

  assign idle   = (state == ST_IDLE);
  assign busy   = (state == ST_ARMED);
  assign swap   = busy & sync;
  assign wr_go  = wr_en & idle & sel_ok;
  // Any write while armed is a protocol error, even to a valid entry.
  assign wr_bad = wr_en & (~idle | ~sel_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      swap_done <= 1'b0;
    end else begin
      swap_done <= swap;
      case (state)
        ST_IDLE:  if (commit) state <= ST_ARMED;
        ST_ARMED: if (sync)   state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // A fresh error takes priority over err_clr in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)                  err <= 1'b0;
    else if (wr_bad | rd_bad) err <= 1'b1;
    else if (err_clr)         err <= 1'b0;
  end

`ifdef TAP_BANK_READBACK_EN
  logic [15:0] rd_deci, rd_hilb, rd_intp, rd_mux;
`endif

  tap_bank_slot #(.LEN(tap_len_deci), .DEF(def_deci)) u_deci (
    .clk(clk), .rst(rst), .we(wr_go && wr_sel == 2'd0), .swap(swap),
    .addr(wr_addr), .data(wr_data), .tap(tap_deci)
`ifdef TAP_BANK_READBACK_EN
    , .rd(rd_deci)
`endif
  );

  tap_bank_slot #(.LEN(m_len), .DEF(def_hilb)) u_hilb (
    .clk(clk), .rst(rst), .we(wr_go && wr_sel == 2'd1), .swap(swap),
    .addr(wr_addr), .data(wr_data), .tap(tap_hilb)
`ifdef TAP_BANK_READBACK_EN
    , .rd(rd_hilb)
`endif
  );

  tap_bank_slot #(.LEN(tap_len_intp), .DEF(def_intp)) u_intp (
    .clk(clk), .rst(rst), .we(wr_go && wr_sel == 2'd2), .swap(swap),
    .addr(wr_addr), .data(wr_data), .tap(tap_intp)
`ifdef TAP_BANK_READBACK_EN
    , .rd(rd_intp)
`endif
  );

`ifdef TAP_BANK_READBACK_EN
  assign rd_bad = rd_en & ~sel_ok;

  always_comb begin
    rd_mux = '0;
    case (wr_sel)
      2'd0:    rd_mux = rd_deci;
      2'd1:    rd_mux = rd_hilb;
      2'd2:    rd_mux = rd_intp;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= sel_ok ? rd_mux : 16'h0000;
  end
`else
  assign rd_bad = 1'b0;
`endif
endmodule

// File: tb/tb_tap_bank_ctrl.sv
// Scoreboard bench for tap_bank_ctrl: stimulus pushes expectations, a negedge monitor pops them.
module tb_tap_bank_ctrl;
  localparam int TD = 21, TH = 8, TI = 21;
  localparam logic [TD-1:0][15:0] DEF_DECI = (TD*16)'(16'd10485) << (10*16);
  localparam logic [TH-1:0][15:0] DEF_HILB = (TH*16)'(16'd100)   << (2*16);
  localparam logic [TI-1:0][15:0] DEF_INTP = (TI*16)'(16'd7)     << (3*16);

  typedef struct packed {
    logic [TD-1:0][15:0] deci;
    logic [TH-1:0][15:0] hilb;
    logic [TI-1:0][15:0] intp;
  } bank_t;

  typedef struct packed {
    logic        busy;
    logic        err;
    logic        sd;
    logic [15:0] rd;
    bank_t       act;
  } snap_t;

  logic clk = 1'b0;
  logic rst, wr_en, commit, sync, err_clr, rd_en;
  logic [1:0]  wr_sel;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic busy, swap_done, err;
  logic [TD-1:0][15:0] tap_deci;
  logic [TH-1:0][15:0] tap_hilb;
  logic [TI-1:0][15:0] tap_intp;
`ifdef TAP_BANK_READBACK_EN
  logic [15:0] rd_data;
`endif

  tap_bank_ctrl #(
    .tap_len_deci(TD), .m_len(TH), .tap_len_intp(TI),
    .def_deci(DEF_DECI), .def_hilb(DEF_HILB), .def_intp(DEF_INTP)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .commit(commit), .sync(sync), .err_clr(err_clr),
`ifdef TAP_BANK_READBACK_EN
    .rd_en(rd_en), .rd_data(rd_data),
`endif
    .busy(busy), .swap_done(swap_done), .err(err),
    .tap_deci(tap_deci), .tap_hilb(tap_hilb), .tap_intp(tap_intp)
  );

  always #5 clk = ~clk;

  int    n_err = 0, n_chk = 0;
  bank_t sq[$];
  snap_t pq[$];
  string pq_name[$];
  logic  probe = 1'b0;
  bank_t e_act, e_sh, s_exp;
  snap_t p_exp;
  string p_nm;
  logic  e_busy, e_err, e_sd;
  logic [15:0] e_rd;

  task automatic cmp(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (swap_done === 1'b1) begin
      if (sq.size() == 0) cmp("unexpected_swap_done", 512'(swap_done), 512'(0));
      else begin
        s_exp = sq.pop_front();
        cmp("swap_deci", 512'(tap_deci), 512'(s_exp.deci));
        cmp("swap_hilb", 512'(tap_hilb), 512'(s_exp.hilb));
        cmp("swap_intp", 512'(tap_intp), 512'(s_exp.intp));
      end
    end
    if (probe) begin
      p_exp = pq.pop_front();
      p_nm  = pq_name.pop_front();
      cmp({p_nm, "_busy"}, 512'(busy), 512'(p_exp.busy));
      cmp({p_nm, "_err"},  512'(err),  512'(p_exp.err));
      cmp({p_nm, "_swap_done"}, 512'(swap_done), 512'(p_exp.sd));
      cmp({p_nm, "_deci"}, 512'(tap_deci), 512'(p_exp.act.deci));
      cmp({p_nm, "_hilb"}, 512'(tap_hilb), 512'(p_exp.act.hilb));
      cmp({p_nm, "_intp"}, 512'(tap_intp), 512'(p_exp.act.intp));
`ifdef TAP_BANK_READBACK_EN
      cmp({p_nm, "_rd_data"}, 512'(rd_data), 512'(p_exp.rd));
`endif
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    wr_en = 0; commit = 0; sync = 0; err_clr = 0; rd_en = 0;
    probe = 0; e_sd = 0;
  endtask

  task automatic check(input string nm);
    pq.push_back('{busy: e_busy, err: e_err, sd: e_sd, rd: e_rd, act: e_act});
    pq_name.push_back(nm);
    probe = 1;
  endtask

  task automatic wr(input logic [1:0] s, input logic [4:0] a, input logic [15:0] d);
    wr_en = 1; wr_sel = s; wr_addr = a; wr_data = d;
  endtask

  // Sync issued while armed: expect every active bus to take the shadow image.
  task automatic do_swap(input string nm);
    sync = 1; sq.push_back(e_sh);
    tick();
    e_act = e_sh; e_busy = 0; e_sd = 1; check(nm);
    tick(); check({nm, "_end"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1; wr_en = 0; commit = 0; sync = 0; err_clr = 0; rd_en = 0;
    wr_sel = 0; wr_addr = 0; wr_data = 0;
    e_act = '{deci: DEF_DECI, hilb: DEF_HILB, intp: DEF_INTP};
    e_sh = e_act; e_busy = 0; e_err = 0; e_sd = 0; e_rd = 0;

    tick(); rst = 0; check("reset");

    // Hilbert write, commit, sync five cycles after commit.
    wr(2'd1, 5'd0, 16'd41721); tick(); e_sh.hilb[0] = 16'd41721; check("wr_shadow_only");
    commit = 1; tick(); e_busy = 1; check("armed");
    for (int i = 0; i < 4; i++) begin tick(); check("armed_hold"); end
    do_swap("swap_hilb");

    // Commit and sync together only arm; the next sync swaps. Last deci index.
    wr(2'd0, 5'd20, 16'h1234); tick(); e_sh.deci[20] = 16'h1234; check("wr_deci_last");
    commit = 1; sync = 1; tick(); e_busy = 1; check("commit_sync_arm_only");
    tick(); check("still_armed");
    do_swap("swap_late");

    // Invalid selections, err_clr versus a same-cycle error.
    wr(2'd0, 5'd21, 16'hFFFF); tick(); e_err = 1; check("bad_deci_addr");
    err_clr = 1; tick(); e_err = 0; check("err_clr");
    wr(2'd3, 5'd0, 16'hFFFF); tick(); e_err = 1; check("bad_sel");
    err_clr = 1; wr(2'd1, 5'd8, 16'hFFFF); tick(); check("clr_vs_new_err");
    err_clr = 1; tick(); e_err = 0; check("err_clr2");

    // Writes while armed are dropped and flagged; commit while armed is ignored.
    commit = 1; tick(); e_busy = 1; check("armed2");
    wr(2'd2, 5'd3, 16'h5555); tick(); e_err = 1; check("armed_write_err");
    err_clr = 1; commit = 1; tick(); e_err = 0; check("commit_in_armed");
    do_swap("swap_unchanged");

    // Reset while armed abandons the swap and restores defaults everywhere.
    wr(2'd0, 5'd10, 16'h0BAD); tick(); e_sh.deci[10] = 16'h0BAD; check("wr_pending");
    commit = 1; tick(); e_busy = 1; check("armed3");
    wr(2'd0, 5'd0, 16'h0001); tick(); e_err = 1; check("armed_write_err2");
    rst = 1; sync = 1; tick(); rst = 0;
    e_act = '{deci: DEF_DECI, hilb: DEF_HILB, intp: DEF_INTP};
    e_sh = e_act; e_busy = 0; e_err = 0; check("rst_armed");
    sync = 1; tick(); check("no_swap_after_rst");
    commit = 1; tick(); e_busy = 1; check("armed4");
    do_swap("swap_defaults");

`ifdef TAP_BANK_READBACK_EN
    wr(2'd2, 5'd3, 16'hFED9); tick(); check("wr_intp_neg");
    rd_en = 1; wr_sel = 2'd2; wr_addr = 5'd3; tick(); e_rd = 16'hFED9; check("readback");
    tick(); check("readback_hold");
    rd_en = 1; wr_sel = 2'd1; wr_addr = 5'd8; tick(); e_rd = 16'h0000; e_err = 1; check("readback_bad");
`endif

    tick(); tick();
    cmp("swap_queue_drained", 512'(sq.size()), 512'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
